led_pattern_sequencer: RTL

//  Wishbone classic master that sequences LED frames into the LED peripheral.

---
 rtl/led_pattern_sequencer_pkg.sv | 22 ++
 rtl/led_pattern_sequencer_timer.sv | 35 +++
 rtl/led_pattern_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types for the LED pattern sequencer: frame layout and FSM state encoding.
package led_pattern_sequencer_pkg;

    typedef logic rgb_led_t;

    typedef struct packed {
        rgb_led_t [3:0] rgb;
        logic     [3:0] green;
    } led_frame_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        REQ,
        WAIT
    } seq_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_timer.sv
// Loadable down-counter with a "count is one" flag; shared by the period wait and the ack timeout.
module led_seq_timer #(
    parameter int unsigned W = 24
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         one_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign one_o = (cnt_q == W'(1));

endmodule

// File: rtl/led_pattern_sequencer.sv
// Wishbone classic master that steps through a small frame table, writing one LED frame per period.
module led_pattern_sequencer
    import led_pattern_sequencer_pkg::*;
#(
    parameter int unsigned NUM_STEPS = 8,
    parameter int unsigned PERIOD_W  = 24,
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [7:0]  LED_ADDR  = 8'h00
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           enable_i,
    input  logic                           loop_i,
    input  logic [$clog2(NUM_STEPS):0]     length_i,
    input  logic [PERIOD_W-1:0]            period_i,
    input  logic                           tbl_we_i,
    input  logic [$clog2(NUM_STEPS)-1:0]   tbl_idx_i,
    input  logic [7:0]                     tbl_data_i,
    output logic                           wb_cyc_o,
    output logic                           wb_stb_o,
    output logic                           wb_we_o,
    output logic [7:0]                     wb_adr_o,
    output logic [7:0]                     wb_dat_o,
    input  logic                           wb_ack_i,
    output logic [$clog2(NUM_STEPS)-1:0]   step_o,
    output logic                           busy_o,
    output logic                           done_pulse_o,
    output logic                           err_o
);

    localparam int unsigned SW  = $clog2(NUM_STEPS);
    localparam int unsigned LW  = SW + 1;
    localparam int unsigned TOW = $clog2(TIMEOUT + 1);
    localparam int unsigned TW  = max_u(PERIOD_W, TOW);

    led_frame_t    tbl_q [NUM_STEPS];
    seq_state_t    state_q;
    logic [SW-1:0] step_q;
    led_frame_t    dat_q;
    logic [7:0]    adr_q;
    logic          cyc_q, stb_q, busy_q, done_q, err_q, en_q, halt_q;

    led_frame_t    fetch_frame;
    logic [LW-1:0] len_eff;
    logic          last_step;
    logic [TW-1:0] tmr_val;
    logic          tmr_load, tmr_en, tmr_one;
    logic          en_rise;

    always_comb begin
        len_eff = length_i;
        if (length_i == '0) begin
            len_eff = LW'(1);
        end else if (length_i > LW'(NUM_STEPS)) begin
            len_eff = LW'(NUM_STEPS);
        end
    end

    // ">=" rather than "==" so a length shrunk below the current step still ends or wraps.
    assign last_step   = ({1'b0, step_q} >= (len_eff - 1'b1));
    assign fetch_frame = (tbl_we_i && (tbl_idx_i == step_q)) ? led_frame_t'(tbl_data_i)
                                                             : tbl_q[step_q];
    assign en_rise     = enable_i && !en_q;

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = TW'(TIMEOUT);
        tmr_en   = (state_q == REQ) || (state_q == WAIT);
        if (state_q == FETCH) begin
            tmr_load = 1'b1;
        end else if ((state_q == REQ) && (wb_ack_i || tmr_one)) begin
            tmr_load = 1'b1;
            tmr_val  = (period_i == '0) ? TW'(1) : TW'(period_i);
        end
    end

    led_seq_timer #(
        .W(TW)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .en_i       (tmr_en),
        .one_o      (tmr_one)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NUM_STEPS; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (tbl_we_i) begin
            tbl_q[tbl_idx_i] <= led_frame_t'(tbl_data_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            step_q  <= '0;
            dat_q   <= '0;
            adr_q   <= '0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            en_q   <= enable_i;
            adr_q  <= LED_ADDR;
            done_q <= 1'b0;
            if (en_rise) err_q <= 1'b0;
            // A finished one-shot stays parked until enable_i is dropped.
            if (!enable_i) halt_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable_i && !halt_q) begin
                        state_q <= FETCH;
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!enable_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        dat_q   <= fetch_frame;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (wb_ack_i || tmr_one) begin
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        if (!wb_ack_i) err_q <= 1'b1;
                        if (enable_i) begin
                            state_q <= WAIT;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (!enable_i) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (tmr_one) begin
                        if (!last_step) begin
                            step_q  <= step_q + 1'b1;
                            state_q <= FETCH;
                        end else if (loop_i) begin
                            step_q  <= '0;
                            state_q <= FETCH;
                        end else begin
                            done_q  <= 1'b1;
                            halt_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = stb_q;
    assign wb_we_o      = cyc_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign step_o       = step_q;
    assign busy_o       = busy_q;
    assign done_pulse_o = done_q;
    assign err_o        = err_q;

endmodule
